systolic_matmul: RTL and testbench

SYSTOLIC_MATMUL -- requirements
Module: systolic_matmul

---
 rtl/systolic_matmul.sv | 218 +++++++++++++++++++++
 tb/tb_systolic_matmul.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/systolic_matmul.sv
// Output-stationary ROWS x COLS systolic matrix multiplier with internal input skew.
// Define SYSTOLIC_MATMUL_SATURATE_EN to saturate accumulators instead of wrapping.
module systolic_pe #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               adv,
  input  logic [BITS_AB-1:0] a_in,
  input  logic [BITS_AB-1:0] b_in,
  output logic [BITS_AB-1:0] a_out,
  output logic [BITS_AB-1:0] b_out,
  output logic [BITS_C-1:0]  acc
);
  localparam int PW = 2 * BITS_AB;

  logic signed [PW-1:0]     prod;
  logic signed [BITS_C-1:0] prod_c;
  logic [BITS_C-1:0]        acc_nxt;

  assign prod   = $signed(a_in) * $signed(b_in);
  assign prod_c = BITS_C'(prod);

`ifdef SYSTOLIC_MATMUL_SATURATE_EN
  logic signed [BITS_C:0] sum;
  always_comb begin
    sum     = {acc[BITS_C-1], acc} + {prod_c[BITS_C-1], prod_c};
    acc_nxt = sum[BITS_C-1:0];
    // top two bits disagree -> overflowed the BITS_C range
    if (sum[BITS_C] != sum[BITS_C-1])
      acc_nxt = sum[BITS_C] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
  end
`else
  assign acc_nxt = acc + prod_c;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (adv) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc_nxt;
    end
  end
endmodule

module systolic_matmul #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int KMAX    = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [$clog2(KMAX+1)-1:0]         k_len,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ROWS-1:0][BITS_AB-1:0]      a_vec,
  input  logic [COLS-1:0][BITS_AB-1:0]      b_vec,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [COLS-1:0][BITS_C-1:0]       c_row,
  output logic [$clog2(ROWS)-1:0]           out_idx,
  output logic                              busy,
  output logic                              done
);
  localparam int KW      = $clog2(KMAX+1);
  localparam int IW      = $clog2(ROWS);
  localparam int FW      = $clog2(ROWS+COLS);
  localparam int FLUSH_N = (ROWS + COLS - 2 > 0) ? ROWS + COLS - 2 : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN} state_t;
  state_t state, nxt;

  logic [KW-1:0] k_reg, kcnt;
  logic [FW-1:0] fcnt;
  logic          clr, adv, done_set;

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    clr       = 1'b0;
    adv       = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE:  if (start) nxt = CLEAR;
      CLEAR: begin
        clr = 1'b1;
        nxt = (k_reg == '0) ? FLUSH : FEED;
      end
      FEED: begin
        in_ready = 1'b1;
        adv      = in_valid;
        if (in_valid && kcnt == k_reg - KW'(1)) nxt = FLUSH;
      end
      FLUSH: begin
        adv = 1'b1;
        if (fcnt == FW'(FLUSH_N - 1)) nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && out_idx == IW'(ROWS - 1)) begin
          nxt      = IDLE;
          done_set = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k_reg   <= '0;
      kcnt    <= '0;
      fcnt    <= '0;
      out_idx <= '0;
      done    <= 1'b0;
    end else begin
      state <= nxt;
      done  <= done_set;
      if (state == IDLE && start) k_reg <= k_len;
      if (clr) begin
        kcnt    <= '0;
        fcnt    <= '0;
        out_idx <= '0;
      end
      if (state == FEED && in_valid) kcnt <= kcnt + KW'(1);
      if (state == FLUSH) fcnt <= fcnt + FW'(1);
      if (out_valid && out_ready)
        out_idx <= (out_idx == IW'(ROWS - 1)) ? '0 : out_idx + IW'(1);
    end
  end

  assign busy = (state != IDLE);

  // lane r of A / lane c of B is delayed r / c advances so operands meet in PE(r,c)
  logic [BITS_AB-1:0] a_sk [ROWS];
  logic [BITS_AB-1:0] b_sk [COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic [BITS_AB-1:0] a_feed;
    assign a_feed = (state == FEED) ? a_vec[r] : '0;
    if (r == 0) begin : g_direct
      assign a_sk[r] = a_feed;
    end else begin : g_sr
      logic [r-1:0][BITS_AB-1:0] sr;
      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) sr <= '0;
        else if (adv) begin
          sr[0] <= a_feed;
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end
      assign a_sk[r] = sr[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    logic [BITS_AB-1:0] b_feed;
    assign b_feed = (state == FEED) ? b_vec[c] : '0;
    if (c == 0) begin : g_direct
      assign b_sk[c] = b_feed;
    end else begin : g_sr
      logic [c-1:0][BITS_AB-1:0] sr;
      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) sr <= '0;
        else if (adv) begin
          sr[0] <= b_feed;
          for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
        end
      end
      assign b_sk[c] = sr[c-1];
    end
  end

  logic [BITS_AB-1:0] ah  [ROWS][COLS+1];
  logic [BITS_AB-1:0] bv  [ROWS+1][COLS];
  logic [BITS_C-1:0]  acc [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign ah[r][0] = a_sk[r];
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (r == 0) begin : g_btop
        assign bv[0][c] = b_sk[c];
      end
      systolic_pe #(.BITS_AB(BITS_AB), .BITS_C(BITS_C)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .adv   (adv),
        .a_in  (ah[r][c]),
        .b_in  (bv[r][c]),
        .a_out (ah[r][c+1]),
        .b_out (bv[r+1][c]),
        .acc   (acc[r][c])
      );
    end
  end

  always_comb begin
    c_row = '0;
    if (out_valid)
      for (int c = 0; c < COLS; c++) c_row[c] = acc[out_idx][c];
  end
endmodule

// File: tb/tb_systolic_matmul.sv
// Directed bench for systolic_matmul (4x4 array): identity, overflow, random with
// handshake toggling, output stall, k_len=0 and mid-job reset.
module tb_systolic_matmul;
  localparam int R = 4, C = 4, AB = 8, BC = 16, KM = 255;
  localparam int KW = $clog2(KM+1);

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [KW-1:0]           k_len;
  logic [R-1:0][AB-1:0]    a_vec;
  logic [C-1:0][AB-1:0]    b_vec;
  logic [C-1:0][BC-1:0]    c_row;
  logic [1:0]              out_idx;

  systolic_matmul #(.BITS_AB(AB), .BITS_C(BC), .ROWS(R), .COLS(C), .KMAX(KM)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid),
    .out_ready(out_ready), .c_row(c_row), .out_idx(out_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int am [R][16];
  int bm [16][C];
  logic [C-1:0][BC-1:0] exp_c [R];
  int first_ov;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compute(input int k);
    logic signed [BC-1:0] t16;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        int acc;
        acc = 0;
        for (int kk = 0; kk < k; kk++) begin
          acc = acc + am[r][kk] * bm[kk][c];
`ifdef SYSTOLIC_MATMUL_SATURATE_EN
          if (acc > 32767) acc = 32767;
          if (acc < -32768) acc = -32768;
`else
          t16 = 16'(acc);
          acc = t16;
`endif
        end
        exp_c[r][c] = 16'(acc);
      end
  endtask

  task automatic run_job(input int k, input bit tog_in, input bit tog_out, input int stall_row);
    int cyc, idx, row, stall, extra_rdy;
    compute(k);
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); in_valid = 1'b0; out_ready = 1'b0;
    cyc = 0; idx = 0; row = 0; stall = 0; extra_rdy = 0; first_ov = -1;
    while (row < R && cyc < 600) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 3);  // must be ignored outside IDLE
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (in_ready && idx >= k) extra_rdy++;
      if (idx < k)
        for (int i = 0; i < R; i++) begin
          a_vec[i] = 8'(am[i][idx]);
          b_vec[i] = 8'(bm[idx][i]);
        end
      in_valid = tog_in ? 1'($urandom_range(0, 1)) : (idx < k);
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        if (first_ov < 0) first_ov = cyc;
        chk("out_idx", 64'(out_idx), 64'(row));
        chk("c_row", c_row, exp_c[row]);
        if (row == stall_row && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else out_ready = tog_out ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) row++;
      end else out_ready = 1'b0;
    end
    chk("rows_drained", 64'(row), 64'(R));
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_idle", busy, 0);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("in_ready_only_in_feed", 64'(extra_rdy), 0);
    chk("vectors_accepted", 64'(idx), 64'(k));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
    a_vec = '0; b_vec = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_idx", 64'(out_idx), 0);
    chk("rst_c_row", c_row, 0);
    rst = 1'b0;

    // identity A, B = 1..16 -> C = B, first out_valid at cycle 12
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        am[i][j] = (i == j) ? 1 : 0;
        bm[i][j] = 4 * i + j + 1;
      end
    run_job(4, 1'b0, 1'b0, -1);
    chk("first_ov_cycle", 64'(first_ov), 12);
    chk("identity_row3_hand", {16'd16, 16'd15, 16'd14, 16'd13}, exp_c[3]);

    // 4 * 127 * 127 = 64516 -> wraps to -1020 or saturates to 32767
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        am[i][j] = 127;
        bm[i][j] = 127;
      end
    run_job(4, 1'b0, 1'b0, -1);
`ifdef SYSTOLIC_MATMUL_SATURATE_EN
    chk("ovf_hand", 64'(exp_c[0][0]), 64'(16'h7fff));
`else
    chk("ovf_hand", 64'(exp_c[0][0]), 64'(16'hfc04));
`endif

    // random signed operands with toggling in_valid / out_ready
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++) begin
        am[i][j] = int'($urandom_range(0, 255)) - 128;
        bm[j][i] = int'($urandom_range(0, 255)) - 128;
      end
    run_job(8, 1'b1, 1'b1, -1);

    // out_ready held low 5 cycles on row 2
    run_job(5, 1'b0, 1'b0, 2);

    // k_len = 0 -> zero rows, no in_ready
    run_job(0, 1'b1, 1'b0, -1);
    chk("k0_row_zero", exp_c[1], 0);

    // reset mid-FEED, then A=B=2, k=3 -> all 12
    @(negedge clk);
    start = 1'b1; k_len = KW'(5); in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("feed_before_rst", in_ready, 1);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_out_idx", 64'(out_idx), 0);
    chk("midrst_c_row", c_row, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        am[i][j] = 2;
        bm[i][j] = 2;
      end
    run_job(3, 1'b0, 1'b0, -1);
    chk("after_rst_hand", 64'(exp_c[2][3]), 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
